// File: rtl/ibex_pkg.sv
// Shared types for the EX request arbiter.
// FSM state encoding and port count.
package ibex_pkg;

    localparam int EXARB_NPORTS = 2;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } exarb_state_e;

endpackage

// File: rtl/ibex_ex_req_arbiter_prio.sv
// Fixed-priority winner select for the EX request arbiter.
// Port 0 wins unless port 1 is alone or its starvation limit is reached.
module ibex_ex_arb_prio
    import ibex_pkg::*;
(
    input  logic [EXARB_NPORTS-1:0] i_valid,
    input  logic                    i_force_p1,
    output logic [EXARB_NPORTS-1:0] o_gnt
);

    logic w_p1;

    assign w_p1     = i_valid[1] & (i_force_p1 | ~i_valid[0]);
    assign o_gnt[1] = w_p1;
    assign o_gnt[0] = i_valid[0] & ~w_p1;

endmodule

// File: rtl/ibex_ex_req_arbiter.sv
// Shares one EX block between the core pipeline (port 0) and an
// auxiliary requester (port 1), one operation at a time.
module ibex_ex_req_arbiter
    import ibex_pkg::*;
#(
    parameter int OpW         = 72,
    parameter int StarveLimit = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [EXARB_NPORTS-1:0]             req_valid_i,
    output logic [EXARB_NPORTS-1:0]             req_ready_o,
    input  logic [EXARB_NPORTS-1:0][OpW-1:0]    req_op_i,
    output logic [OpW-1:0]                      ex_op_o,
    output logic                                ex_start_o,
    output logic                                ex_en_o,
    input  logic                                ex_valid_i,
    input  logic [31:0]                         ex_result_i,
    output logic                                multdiv_ready_o,
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic                                rsp_id_o,
    output logic [31:0]                         rsp_data_o
);

    localparam int SW = $clog2(StarveLimit + 1);
    localparam logic [SW-1:0] StarveMax = SW'(StarveLimit);

    exarb_state_e                r_state;
    exarb_state_e                w_state_nxt;
    logic                        r_first;
    logic [OpW-1:0]              r_op;
    logic                        r_id;
    logic [31:0]                 r_data;
    logic [SW-1:0]               r_starve;

    logic [EXARB_NPORTS-1:0]     w_gnt;
    logic                        w_gnt_id;
    logic                        w_force;
    logic                        w_hs;
    logic                        w_cap;

    assign w_force  = (r_starve == StarveMax);
    assign w_gnt_id = w_gnt[1];

    ibex_ex_arb_prio u_prio (
        .i_valid    (req_valid_i),
        .i_force_p1 (w_force),
        .o_gnt      (w_gnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        req_ready_o     = '0;
        ex_start_o      = 1'b0;
        ex_en_o         = 1'b0;
        multdiv_ready_o = 1'b0;
        rsp_valid_o     = 1'b0;
        w_hs            = 1'b0;
        w_cap           = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!flush_i && !rst_i) begin
                    req_ready_o = w_gnt;
                    if (|w_gnt) begin
                        w_hs        = 1'b1;
                        w_state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                // A flushed op must not see a qualified enable.
                if (flush_i) begin
                    w_state_nxt = IDLE;
                end else begin
                    ex_en_o         = 1'b1;
                    ex_start_o      = r_first;
                    multdiv_ready_o = 1'b1;
                    if (ex_valid_i) begin
                        w_cap       = 1'b1;
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (flush_i || rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_first  <= 1'b0;
            r_op     <= '0;
            r_id     <= 1'b0;
            r_data   <= '0;
            r_starve <= '0;
        end else begin
            r_first <= w_hs;
            if (w_hs) begin
                r_op <= req_op_i[w_gnt_id];
                r_id <= w_gnt_id;
                if (w_gnt_id) begin
                    r_starve <= '0;
                end else if (req_valid_i[1] && !w_force) begin
                    r_starve <= r_starve + 1'b1;
                end
            end
            if (w_cap) begin
                r_data <= ex_result_i;
            end
        end
    end

    assign ex_op_o    = r_op;
    assign rsp_id_o   = r_id;
    assign rsp_data_o = r_data;

endmodule

// File: tb/tb_ibex_ex_req_arbiter.sv
// Scoreboard bench for the EX request arbiter.
// Bench plays both requesters and the EX block.
module tb_ibex_ex_req_arbiter;

    localparam int OpW = 72;
    localparam logic [6:0] OP_ADD = 7'h00;
    localparam logic [6:0] OP_MUL = 7'h30;
    localparam logic [6:0] OP_DIV = 7'h33;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic                   flush_i;
    logic [1:0]             req_valid_i;
    logic [1:0]             req_ready_o;
    logic [1:0][OpW-1:0]    req_op_i;
    logic [OpW-1:0]         ex_op_o;
    logic                   ex_start_o;
    logic                   ex_en_o;
    logic                   ex_valid_i;
    logic [31:0]            ex_result_i;
    logic                   multdiv_ready_o;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic                   rsp_id_o;
    logic [31:0]            rsp_data_o;

    int             n_chk = 0;
    int             n_fail = 0;
    int             sv = 0;
    int             g;
    logic [OpW-1:0] exp_op;
    logic [31:0]    exp_res;
    logic [32:0]    sb[$];
    logic [32:0]    w_exp;

    always #5 clk = ~clk;

    ibex_ex_req_arbiter #(.OpW(OpW), .StarveLimit(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_op_i        (req_op_i),
        .ex_op_o         (ex_op_o),
        .ex_start_o      (ex_start_o),
        .ex_en_o         (ex_en_o),
        .ex_valid_i      (ex_valid_i),
        .ex_result_i     (ex_result_i),
        .multdiv_ready_o (multdiv_ready_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_id_o        (rsp_id_o),
        .rsp_data_o      (rsp_data_o)
    );

    function automatic logic [OpW-1:0] mk(input logic [6:0] opc,
                                          input logic sgn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        return {opc, sgn, a, b};
    endfunction

    task automatic chk(input string tag,
                       input logic [OpW-1:0] got,
                       input logic [OpW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive requests for one IDLE cycle; model the winner and starvation.
    task automatic issue(input logic [1:0] vld,
                         input logic [OpW-1:0] o0,
                         input logic [OpW-1:0] o1,
                         input logic [31:0] r0,
                         input logic [31:0] r1,
                         output int gw);
        req_valid_i = vld;
        req_op_i[0] = o0;
        req_op_i[1] = o1;
        #1;
        if (vld[1] && (sv == 4 || !vld[0])) gw = 1;
        else if (vld[0]) gw = 0;
        else gw = -1;
        chk("gnt", req_ready_o,
            gw < 0 ? 2'b00 : (gw == 1 ? 2'b10 : 2'b01));
        if (gw == 0 && vld[1]) sv = (sv < 4) ? sv + 1 : 4;
        if (gw == 1) sv = 0;
        if (gw >= 0) begin
            exp_op  = (gw == 1) ? o1 : o0;
            exp_res = (gw == 1) ? r1 : r0;
            sb.push_back({(gw == 1), exp_res});
        end
    endtask

    // Run EXEC for lat cycles, then hold RESP for hold cycles.
    task automatic serve(input int lat, input int hold, input logic drop);
        tick();
        if (drop) req_valid_i = 2'b00;
        for (int k = 1; k <= lat; k++) begin
            ex_valid_i  = (k == lat);
            ex_result_i = (k == lat) ? exp_res : 32'h0;
            #1;
            chk("start", ex_start_o, (k == 1));
            chk("en", ex_en_o, 1'b1);
            chk("op", ex_op_o, exp_op);
            chk("mdr", multdiv_ready_o, 1'b1);
            chk("rv_exec", rsp_valid_o, 1'b0);
            tick();
        end
        ex_valid_i  = 1'b0;
        ex_result_i = 32'h0;
        for (int h = 0; h < hold; h++) begin
            rsp_ready_i = 1'b0;
            #1;
            chk("rv_hold", rsp_valid_o, 1'b1);
            chk("data_hold", rsp_data_o, exp_res);
            chk("rdy_resp", req_ready_o, 2'b00);
            tick();
        end
        rsp_ready_i = 1'b1;
        #1;
        chk("rv", rsp_valid_o, 1'b1);
        chk("en_resp", ex_en_o, 1'b0);
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb: response %0h with nothing expected",
                     {rsp_id_o, rsp_data_o});
        end else begin
            w_exp = sb.pop_front();
            if ({rsp_id_o, rsp_data_o} !== w_exp) begin
                n_fail++;
                $display("FAIL sb: got %0h expected %0h",
                         {rsp_id_o, rsp_data_o}, w_exp);
            end
        end
        tick();
        rsp_ready_i = 1'b0;
        #1;
        chk("rv_idle", rsp_valid_o, 1'b0);
    endtask

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = 2'b11;
        req_op_i    = '0;
        ex_valid_i  = 1'b0;
        ex_result_i = 32'h0;
        rsp_ready_i = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_rdy", req_ready_o, 2'b00);
        chk("rst_start", ex_start_o, 1'b0);
        chk("rst_en", ex_en_o, 1'b0);
        chk("rst_mdr", multdiv_ready_o, 1'b0);
        chk("rst_rv", rsp_valid_o, 1'b0);
        chk("rst_id", rsp_id_o, 1'b0);
        chk("rst_data", rsp_data_o, 32'h0);
        chk("rst_op", ex_op_o, '0);
        rst_i       = 1'b0;
        req_valid_i = 2'b00;
        tick();

        // Single-cycle ADD on port 0
        issue(2'b01, mk(OP_ADD, 1'b0, 32'd5, 32'd7), '0, 32'd12, 32'd0, g);
        serve(1, 0, 1'b1);

        // Both ports continuously valid
        for (int i = 0; i < 10; i++) begin
            issue(2'b11, mk(OP_ADD, 1'b0, i, 32'd100),
                  mk(OP_ADD, 1'b0, i, 32'd200),
                  32'(i + 100), 32'(i + 200), g);
            chk("order", req_ready_o, (i % 5 == 4) ? 2'b10 : 2'b01);
            serve(1, 0, 1'b0);
        end
        req_valid_i = 2'b00;

        // Long DIV on port 1
        issue(2'b10, '0, mk(OP_DIV, 1'b1, 32'd100, 32'd7),
              32'd0, 32'd14, g);
        serve(37, 0, 1'b1);

        // Response backpressure
        issue(2'b01, mk(OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'd2), '0,
              32'd1, 32'd0, g);
        serve(1, 5, 1'b1);

        // Flush in IDLE suppresses grant
        req_valid_i = 2'b01;
        flush_i     = 1'b1;
        #1;
        chk("flush_idle", req_ready_o, 2'b00);
        tick();
        flush_i = 1'b0;

        // Flush on cycle 3 of a MUL, same cycle as ex_valid_i
        issue(2'b01, mk(OP_MUL, 1'b0, 32'd6, 32'd7), '0, 32'd42, 32'd0, g);
        tick();
        req_valid_i = 2'b00;
        for (int k = 1; k <= 2; k++) begin
            #1;
            chk("mul_en", ex_en_o, 1'b1);
            tick();
        end
        ex_valid_i  = 1'b1;
        ex_result_i = 32'd42;
        flush_i     = 1'b1;
        #1;
        chk("flush_en", ex_en_o, 1'b0);
        tick();
        flush_i    = 1'b0;
        ex_valid_i = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("flush_rv", rsp_valid_o, 1'b0);
        chk("flush_mdr", multdiv_ready_o, 1'b0);
        issue(2'b01, mk(OP_MUL, 1'b0, 32'd3, 32'd9), '0, 32'd27, 32'd0, g);
        serve(2, 0, 1'b1);

        // Flush in RESP drops the response
        issue(2'b01, mk(OP_ADD, 1'b0, 32'd1, 32'd1), '0, 32'd2, 32'd0, g);
        tick();
        req_valid_i = 2'b00;
        ex_valid_i  = 1'b1;
        ex_result_i = 32'd2;
        tick();
        ex_valid_i  = 1'b0;
        flush_i     = 1'b1;
        rsp_ready_i = 1'b1;
        #1;
        chk("fresp_rv", rsp_valid_o, 1'b1);
        tick();
        flush_i     = 1'b0;
        rsp_ready_i = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("fresp_drop", rsp_valid_o, 1'b0);

        // Reset in EXEC with port 1 about to be forced
        for (int j = 0; j < 3; j++) begin
            issue(2'b11, mk(OP_ADD, 1'b0, j, 32'd300),
                  mk(OP_ADD, 1'b0, j, 32'd400),
                  32'(j + 300), 32'(j + 400), g);
            serve(1, 0, 1'b0);
        end
        issue(2'b11, mk(OP_ADD, 1'b0, 32'd9, 32'd300),
              mk(OP_ADD, 1'b0, 32'd9, 32'd400), 32'd309, 32'd409, g);
        tick();
        rst_i = 1'b1;
        #1;
        chk("pre_rst_en", ex_en_o, 1'b1);
        tick();
        rst_i = 1'b0;
        sv    = 0;
        sb.delete();
        #1;
        chk("mrst_en", ex_en_o, 1'b0);
        chk("mrst_start", ex_start_o, 1'b0);
        chk("mrst_op", ex_op_o, '0);
        chk("mrst_rv", rsp_valid_o, 1'b0);
        chk("mrst_data", rsp_data_o, 32'h0);
        chk("mrst_id", rsp_id_o, 1'b0);
        issue(2'b11, mk(OP_ADD, 1'b0, 32'd10, 32'd20),
              mk(OP_ADD, 1'b0, 32'd10, 32'd30), 32'd30, 32'd40, g);
        serve(1, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
